semaforo_monitor: RTL



---
 rtl/semaforo_monitor_if.sv | 29 ++
 rtl/semaforo_monitor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/semaforo_monitor_if.sv
// Lamp/fault bundle between the intersection top (master) and the safety monitor (slave).
// cycles_o is only meaningful when SEMAFORO_MONITOR_CYCLES_EN is defined.
interface semaforo_monitor_if;
  logic        tick_i;
  logic        clear_i;
  logic        red1_i;
  logic        yellow1_i;
  logic        green1_i;
  logic        red2_i;
  logic        yellow2_i;
  logic        green2_i;
  logic        fault_o;
  logic [2:0]  fault_code_o;
  logic [15:0] cycles_o;

  modport master (
    output tick_i, clear_i,
    output red1_i, yellow1_i, green1_i,
    output red2_i, yellow2_i, green2_i,
    input  fault_o, fault_code_o, cycles_o
  );

  modport slave (
    input  tick_i, clear_i,
    input  red1_i, yellow1_i, green1_i,
    input  red2_i, yellow2_i, green2_i,
    output fault_o, fault_code_o, cycles_o
  );
endinterface

// File: rtl/semaforo_monitor.sv
// Two-light traffic signal safety monitor: lamp sampling, protocol checks, sticky fault code.
// Optional macro SEMAFORO_MONITOR_CYCLES_EN builds the completed light-1 cycle counter.
module semaforo_monitor #(
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned MAX_PHASE  = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  semaforo_monitor_if.slave mon
);

  localparam int unsigned LAMP_W = 3;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CYC_W  = 16;

  localparam logic [LAMP_W-1:0] LAMP_R = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_Y = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_G = 3'b001;

  localparam logic [CODE_W-1:0] CODE_NONE     = 3'd0;
  localparam logic [CODE_W-1:0] CODE_ONEHOT1  = 3'd1;
  localparam logic [CODE_W-1:0] CODE_ONEHOT2  = 3'd2;
  localparam logic [CODE_W-1:0] CODE_CONFLICT = 3'd3;
  localparam logic [CODE_W-1:0] CODE_ILLEGAL  = 3'd4;
  localparam logic [CODE_W-1:0] CODE_SHORT_Y  = 3'd5;
  localparam logic [CODE_W-1:0] CODE_TIMEOUT  = 3'd6;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PHASE);
  localparam logic [CNT_W-1:0] MIN_Y   = CNT_W'(MIN_YELLOW);

  function automatic logic is_one_hot(input logic [LAMP_W-1:0] s);
    return (s == LAMP_R) || (s == LAMP_Y) || (s == LAMP_G);
  endfunction

  function automatic logic legal_step(input logic [LAMP_W-1:0] p, input logic [LAMP_W-1:0] c);
    return ((p == LAMP_G) && (c == LAMP_Y)) ||
           ((p == LAMP_Y) && (c == LAMP_R)) ||
           ((p == LAMP_R) && (c == LAMP_G));
  endfunction

  function automatic logic non_red(input logic [LAMP_W-1:0] s);
    return (s != '0) && !s[2];
  endfunction

  logic [LAMP_W-1:0] cur1, cur2, prv1, prv2;
  logic              tick_q;
  logic              samp_v;
  logic              prime;

  logic [CNT_W-1:0]  cnt1, cnt2;
  logic [CNT_W-1:0]  cnt1_nxt, cnt2_nxt;

  logic              fault_q, fault_nxt;
  logic [CODE_W-1:0] code_q, code_nxt, det;

  logic oh1, oh2, chg1, chg2;
  logic conflict, illegal, short_y, timeout;

  // Stage 1: lamp/tick capture; samp_v marks a real sample in cur, prime a real one in prv.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur1   <= '0;
      cur2   <= '0;
      prv1   <= '0;
      prv2   <= '0;
      tick_q <= 1'b0;
      samp_v <= 1'b0;
      prime  <= 1'b0;
    end else begin
      cur1   <= {mon.red1_i, mon.yellow1_i, mon.green1_i};
      cur2   <= {mon.red2_i, mon.yellow2_i, mon.green2_i};
      prv1   <= cur1;
      prv2   <= cur2;
      tick_q <= mon.tick_i;
      samp_v <= 1'b1;
      prime  <= samp_v;
    end
  end

  // Stage 2: phase counters, protocol checks and sticky fault resolution.
  always_comb begin
    oh1      = is_one_hot(cur1);
    oh2      = is_one_hot(cur2);
    chg1     = prime && (cur1 != prv1);
    chg2     = prime && (cur2 != prv2);

    cnt1_nxt = cnt1;
    if (chg1) begin
      cnt1_nxt = '0;
    end else if (tick_q && (cnt1 < MAX_CNT)) begin
      cnt1_nxt = cnt1 + CNT_W'(1);
    end

    cnt2_nxt = cnt2;
    if (chg2) begin
      cnt2_nxt = '0;
    end else if (tick_q && (cnt2 < MAX_CNT)) begin
      cnt2_nxt = cnt2 + CNT_W'(1);
    end

    conflict = non_red(cur1) && non_red(cur2);
    illegal  = (chg1 && oh1 && is_one_hot(prv1) && !legal_step(prv1, cur1)) ||
               (chg2 && oh2 && is_one_hot(prv2) && !legal_step(prv2, cur2));
    short_y  = (prime && (prv1 == LAMP_Y) && (cur1 == LAMP_R) && (cnt1 < MIN_Y)) ||
               (prime && (prv2 == LAMP_Y) && (cur2 == LAMP_R) && (cnt2 < MIN_Y));
    timeout  = (cnt1_nxt == MAX_CNT) || (cnt2_nxt == MAX_CNT);

    det = CODE_NONE;
    if (samp_v) begin
      if (!oh1)          det = CODE_ONEHOT1;
      else if (!oh2)     det = CODE_ONEHOT2;
      else if (conflict) det = CODE_CONFLICT;
      else if (illegal)  det = CODE_ILLEGAL;
      else if (short_y)  det = CODE_SHORT_Y;
      else if (timeout)  det = CODE_TIMEOUT;
    end

    // A fresh detection beats clear; otherwise the first code stays latched.
    fault_nxt = fault_q;
    code_nxt  = code_q;
    if ((det != CODE_NONE) && (mon.clear_i || !fault_q)) begin
      fault_nxt = 1'b1;
      code_nxt  = det;
    end else if (mon.clear_i) begin
      fault_nxt = 1'b0;
      code_nxt  = CODE_NONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt1    <= '0;
      cnt2    <= '0;
      fault_q <= 1'b0;
      code_q  <= CODE_NONE;
    end else begin
      if (samp_v) begin
        cnt1 <= cnt1_nxt;
        cnt2 <= cnt2_nxt;
      end
      fault_q <= fault_nxt;
      code_q  <= code_nxt;
    end
  end

  assign mon.fault_o      = fault_q;
  assign mon.fault_code_o = code_q;

`ifdef SEMAFORO_MONITOR_CYCLES_EN
  logic [CYC_W-1:0] cycles_q;

  // One completed light-1 cycle per R->G; keeps counting while faulted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycles_q <= '0;
    end else if (samp_v && prime && (prv1 == LAMP_R) && (cur1 == LAMP_G)) begin
      cycles_q <= cycles_q + CYC_W'(1);
    end
  end

  assign mon.cycles_o = cycles_q;
`else
  assign mon.cycles_o = '0;
`endif

endmodule
